// File: rtl/counter_wrap_tracker_if.sv
// Event stream from the wrap tracker to its consumer (valid/ready).
// Latency: none, this is wiring only.
// Backpressure: the consumer holds ev_ready low to stall the head event.
interface counter_wrap_tracker_if #(
    parameter int POS_W = 16
);
    logic             ev_valid;
    logic             ev_ready;
    logic [1:0]       ev_code;
    logic [POS_W-1:0] ev_pos;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_pos,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_pos,
        output ev_ready
    );
endinterface

// File: rtl/counter_wrap_tracker.sv
// Tracks an up/down counter's qd, extends it to {hi, qd} across wraps, logs wrap/load/jump events.
// Latency: pos one cycle after qd is sampled; an event reaches an empty FIFO head in the same cycle.
// Backpressure: events queue in a FIFO_DEPTH FIFO; a push into a full FIFO without a pop is dropped and sets ev_overflow.
// Optional macro WRAP_TRACK_JUMP_CHECK_EN: illegal jumps push a JUMP event and set jump_err.
module counter_wrap_tracker #(
    parameter int WIDTH      = 8,
    parameter int HI_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic [WIDTH-1:0]          qd,
    input  logic                      load,
    input  logic                      up_down,
    output logic [WIDTH+HI_WIDTH-1:0] pos,
    counter_wrap_tracker_if.master    ev_if,
    output logic                      ev_overflow,
    output logic                      jump_err
);
    localparam int POS_W = WIDTH + HI_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef WRAP_TRACK_JUMP_CHECK_EN
    localparam logic [1:0] EV_JUMP = 2'b00;
`endif
    localparam logic [1:0] EV_WRAP_UP = 2'b01;
    localparam logic [1:0] EV_WRAP_DN = 2'b10;
    localparam logic [1:0] EV_LOAD    = 2'b11;

    localparam logic [WIDTH-1:0] Q_ONES = '1;
    localparam logic [WIDTH-1:0] Q_ONE  = WIDTH'(1);

    typedef enum logic {S_PRIME, S_TRACK} state_t;

    typedef struct packed {
        logic [1:0]       code;
        logic [POS_W-1:0] pos;
    } ev_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      q_prev_q, q_prev_d;
    logic [HI_WIDTH-1:0]   hi_q, hi_d;
    logic                  load_dly_q, load_dly_d;
    logic                  ud_dly_q, ud_dly_d;
    logic                  ovf_q, ovf_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    ev_t                   mem_q [FIFO_DEPTH];
    ev_t                   mem_d [FIFO_DEPTH];

    logic [WIDTH-1:0]      delta;
    logic                  ev_push;
    logic                  ev_is_jump;
    ev_t                   ev_new;
    logic                  fifo_full;
    logic                  fifo_pop;
    logic                  push_ok;

    // FSM state register; clear returns to PRIME.
    always_ff @(posedge clk) begin
        if (clear) state_q <= S_PRIME;
        else       state_q <= state_d;
    end

    // Next state: PRIME lasts exactly one cycle, then tracking continues until clear.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PRIME: state_d = S_TRACK;
            S_TRACK: state_d = S_TRACK;
            default: state_d = S_PRIME;
        endcase
    end

    // Classify each qd change and compute the tracker registers and any event to log.
    always_comb begin
        delta      = qd - q_prev_q;
        q_prev_d   = qd;
        hi_d       = hi_q;
        load_dly_d = load;
        ud_dly_d   = up_down;
        ev_push    = 1'b0;
        ev_is_jump = 1'b0;
        ev_new     = '0;
        case (state_q)
            S_PRIME: begin
                hi_d = '0;
            end
            default: begin
                if (load_dly_q) begin
                    ev_push     = 1'b1;
                    ev_new.code = EV_LOAD;
                end else if (delta == '0) begin
                    ev_push = 1'b0;
                end else if (delta == Q_ONE && ud_dly_q) begin
                    if (q_prev_q == Q_ONES && qd == '0) begin
                        hi_d        = hi_q + HI_WIDTH'(1);
                        ev_push     = 1'b1;
                        ev_new.code = EV_WRAP_UP;
                    end
                end else if (delta == Q_ONES && !ud_dly_q) begin
                    if (q_prev_q == '0 && qd == Q_ONES) begin
                        hi_d        = hi_q - HI_WIDTH'(1);
                        ev_push     = 1'b1;
                        ev_new.code = EV_WRAP_DN;
                    end
                end else begin
                    // Illegal jump: q_prev already resyncs to qd, hi is left alone.
                    ev_is_jump = 1'b1;
`ifdef WRAP_TRACK_JUMP_CHECK_EN
                    ev_push     = 1'b1;
                    ev_new.code = EV_JUMP;
`endif
                end
            end
        endcase
        ev_new.pos = {hi_d, qd};
    end

    // Event FIFO control: a pop frees a slot for a same-cycle push when full.
    always_comb begin
        fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));
        fifo_pop  = (cnt_q != '0) && ev_if.ev_ready;
        push_ok   = ev_push && (!fifo_full || fifo_pop);
        ovf_d     = ovf_q | (ev_push && fifo_full && !fifo_pop);
        wr_ptr_d  = push_ok  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = fifo_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d     = cnt_q + CNT_W'(push_ok) - CNT_W'(fifo_pop);
        mem_d     = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = ev_new;
    end

    // Datapath and FIFO registers; clear flushes everything and discards any in-flight handshake.
    always_ff @(posedge clk) begin
        if (clear) begin
            q_prev_q   <= '0;
            hi_q       <= '0;
            load_dly_q <= 1'b0;
            ud_dly_q   <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            mem_q      <= '{default: '0};
        end else begin
            q_prev_q   <= q_prev_d;
            hi_q       <= hi_d;
            load_dly_q <= load_dly_d;
            ud_dly_q   <= ud_dly_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

`ifdef WRAP_TRACK_JUMP_CHECK_EN
    logic jump_err_q, jump_err_d;

    // Sticky illegal-jump flag.
    always_comb begin
        jump_err_d = jump_err_q | ev_is_jump;
    end

    // Jump flag register, cleared only by clear.
    always_ff @(posedge clk) begin
        if (clear) jump_err_q <= 1'b0;
        else       jump_err_q <= jump_err_d;
    end

    assign jump_err = jump_err_q;
`else
    logic unused_jump;
    assign unused_jump = ev_is_jump;
    assign jump_err    = 1'b0;
`endif

    // Outputs are driven straight from flops (head entry is a mux of FIFO registers).
    assign pos            = {hi_q, q_prev_q};
    assign ev_overflow    = ovf_q;
    assign ev_if.ev_valid = (cnt_q != '0);
    assign ev_if.ev_code  = mem_q[rd_ptr_q].code;
    assign ev_if.ev_pos   = mem_q[rd_ptr_q].pos;

endmodule

// File: tb/tb_counter_wrap_tracker.sv
// Self-checking bench: directed scenarios then randomized counter traffic against a queue-based model.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: ev_ready is driven low/high by the stimulus to exercise queueing and overflow.
module tb_counter_wrap_tracker;
    logic        clk;
    logic        clear;
    logic [7:0]  qd;
    logic        load;
    logic        up_down;
    logic [15:0] pos;
    logic        ev_overflow;
    logic        jump_err;

    counter_wrap_tracker_if #(.POS_W(16)) ev_if ();

    counter_wrap_tracker #(
        .WIDTH(8), .HI_WIDTH(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .clear(clear), .qd(qd), .load(load), .up_down(up_down),
        .pos(pos), .ev_if(ev_if), .ev_overflow(ev_overflow), .jump_err(jump_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  code;
        logic [15:0] pos;
    } mev_t;

    int   vecs = 0;
    int   miss = 0;

    // Reference model: counter position as integers plus a queue of pending events.
    bit   m_primed;
    int   m_prev, m_hi;
    bit   m_ld, m_ud, m_ovf, m_jerr;
    mev_t m_q[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit   pop;
        bit   have_ev;
        mev_t e;
        int   q;
        if (clear) begin
            m_primed = 0; m_prev = 0; m_hi = 0; m_ld = 0; m_ud = 0;
            m_ovf = 0; m_jerr = 0; m_q.delete();
            return;
        end
        pop     = (m_q.size() > 0) && ev_if.ev_ready;
        have_ev = 0;
        q       = int'(qd);
        if (!m_primed) begin
            m_primed = 1; m_hi = 0;
        end else if (m_ld) begin
            have_ev = 1; e.code = 2'b11;
        end else if (q == m_prev) begin
            have_ev = 0;
        end else if (q == (m_prev + 1) % 256 && m_ud) begin
            if (m_prev == 255) begin
                m_hi = (m_hi + 1) % 256; have_ev = 1; e.code = 2'b01;
            end
        end else if (q == (m_prev + 255) % 256 && !m_ud) begin
            if (m_prev == 0) begin
                m_hi = (m_hi + 255) % 256; have_ev = 1; e.code = 2'b10;
            end
        end else begin
`ifdef WRAP_TRACK_JUMP_CHECK_EN
            have_ev = 1; e.code = 2'b00; m_jerr = 1;
`endif
        end
        m_prev = q; m_ld = load; m_ud = up_down;
        e.pos  = 16'(m_hi * 256 + m_prev);
        if (pop) void'(m_q.pop_front());
        if (have_ev) begin
            if (m_q.size() < 4) m_q.push_back(e);
            else                m_ovf = 1;
        end
    endtask

    task automatic compare();
        check("pos", 32'(pos), 32'(m_hi * 256 + m_prev));
        check("ev_valid", 32'(ev_if.ev_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("ev_code", 32'(ev_if.ev_code), 32'(m_q[0].code));
            check("ev_pos", 32'(ev_if.ev_pos), 32'(m_q[0].pos));
        end
        check("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
        check("jump_err", 32'(jump_err), 32'(m_jerr));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    function automatic logic [7:0] pick_load();
        int s;
        s = $urandom_range(0, 4);
        case (s)
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'hFE;
            3: return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int  n;
        int  r;
        bit  dir;

        clear = 1'b1; qd = 8'h10; load = 1'b0; up_down = 1'b1; ev_if.ev_ready = 1'b1;
        m_primed = 0; m_prev = 0; m_hi = 0; m_ld = 0; m_ud = 0; m_ovf = 0; m_jerr = 0;

        // Reset and prime.
        tick();
        check("rst_pos", 32'(pos), 32'h0);
        check("rst_valid", 32'(ev_if.ev_valid), 32'h0);
        check("rst_code", 32'(ev_if.ev_code), 32'h0);
        check("rst_evpos", 32'(ev_if.ev_pos), 32'h0);
        check("rst_ovf", 32'(ev_overflow), 32'h0);
        check("rst_jerr", 32'(jump_err), 32'h0);
        tick();
        clear = 1'b0;
        tick();
        tick();
        check("prime_pos", 32'(pos), 32'h0010);
        check("prime_valid", 32'(ev_if.ev_valid), 32'h0);

        // Load 0xFE, then step up through the wrap.
        load = 1'b1; tick();
        load = 1'b0; qd = 8'hFE; tick();
        check("load_fe_code", 32'(ev_if.ev_code), 32'h3);
        check("load_fe_pos", 32'(ev_if.ev_pos), 32'h00FE);
        qd = 8'hFF; tick();
        qd = 8'h00; up_down = 1'b0; tick();
        check("wrap_up_pos", 32'(pos), 32'h0100);
        check("wrap_up_valid", 32'(ev_if.ev_valid), 32'h1);
        check("wrap_up_code", 32'(ev_if.ev_code), 32'h1);
        check("wrap_up_evpos", 32'(ev_if.ev_pos), 32'h0100);

        // Down wrap back below 0x0100.
        qd = 8'hFF; tick();
        check("wrap_dn_pos", 32'(pos), 32'h00FF);
        check("wrap_dn_code", 32'(ev_if.ev_code), 32'h2);
        check("wrap_dn_evpos", 32'(ev_if.ev_pos), 32'h00FF);

        // Load resync to 0x5A.
        load = 1'b1; tick();
        load = 1'b0; qd = 8'h5A; tick();
        check("load_5a_code", 32'(ev_if.ev_code), 32'h3);
        check("load_5a_evpos", 32'(ev_if.ev_pos), 32'h005A);
        check("load_5a_jerr", 32'(jump_err), 32'h0);

        // Illegal jump 0x20 -> 0x30.
        load = 1'b1; tick();
        load = 1'b0; qd = 8'h20; tick();
        tick();
        qd = 8'h30; tick();
        check("jump_pos", 32'(pos), 32'h0030);
`ifdef WRAP_TRACK_JUMP_CHECK_EN
        check("jump_valid", 32'(ev_if.ev_valid), 32'h1);
        check("jump_code", 32'(ev_if.ev_code), 32'h0);
        check("jump_evpos", 32'(ev_if.ev_pos), 32'h0030);
        check("jump_err", 32'(jump_err), 32'h1);
`else
        check("jump_valid", 32'(ev_if.ev_valid), 32'h0);
        check("jump_err", 32'(jump_err), 32'h0);
`endif
        tick();

        // Overflow: five wraps with the consumer stalled.
        load = 1'b1; tick();
        load = 1'b0; qd = 8'hFF; tick();
        tick();
        ev_if.ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dir = (qd == 8'hFF);
            up_down = dir; tick();
            qd = dir ? 8'h00 : 8'hFF; tick();
        end
        check("ovf_set", 32'(ev_overflow), 32'h1);
        check("ovf_valid", 32'(ev_if.ev_valid), 32'h1);
        check("ovf_head_code", 32'(ev_if.ev_code), 32'h1);

        // Push while full with a same-cycle pop: nothing dropped, still 4 entries.
        dir = (qd == 8'hFF);
        up_down = dir; tick();
        ev_if.ev_ready = 1'b1;
        qd = dir ? 8'h00 : 8'hFF; tick();
        ev_if.ev_ready = 1'b0; tick();
        ev_if.ev_ready = 1'b1;
        n = 0;
        while (ev_if.ev_valid && n < 10) begin
            tick();
            n++;
        end
        check("full_pop_count", 32'(n), 32'd4);

        // Randomized counter traffic with occasional clears, loads and jumps.
        for (int i = 0; i < 3000; i++) begin
            r       = $urandom_range(0, 99);
            clear   = (r == 0);
            load    = (r >= 1 && r < 9);
            up_down = 1'($urandom_range(0, 1));
            ev_if.ev_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (load)        qd = pick_load();
            else if (r < 16) qd = 8'($urandom_range(0, 255));
            else if (r < 40) qd = qd;
            else             qd = up_down ? qd + 8'd1 : qd - 8'd1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/counter_wrap_tracker.md
# counter_wrap_tracker

Downstream monitor for the 8-bit up/down behavioural counter: samples the counter's `qd` output every cycle, detects wrap-around in both directions, and maintains an extended 16-bit position (`{hi, qd}`). Wrap, load and (optionally) illegal-jump events go into a small event FIFO drained over a valid/ready handshake. It sits between the counter and any consumer that needs a position wider than 8 bits or an event log of counter discontinuities.

## Interface
- `WIDTH`, 8: width of the observed counter value.
- `HI_WIDTH`, 8: width of the wrap extension; position width is `WIDTH+HI_WIDTH`.
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, at least 2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `clear`  in  1  reset, synchronous, active-high; highest priority.
- `qd`  in  WIDTH  counter output, sampled every cycle.
- `load`  in  1  counter load/clear strobe, asserted in the same cycle the counter samples it; marks the next `qd` change as expected.
- `up_down`  in  1  counter direction in the same cycle: 1 = up, 0 = down.
- `pos`  out  WIDTH+HI_WIDTH  extended position `{hi, q_prev}`.
- `ev_valid`  out  1  FIFO head holds an event.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_code`  out  2  head event: 00 JUMP, 01 WRAP_UP, 10 WRAP_DN, 11 LOAD.
- `ev_pos`  out  WIDTH+HI_WIDTH  `pos` value after the event was applied.
- `ev_overflow`  out  1  sticky: an event was dropped because the FIFO was full.
- `jump_err`  out  1  sticky: an illegal jump was seen.

## Operation
- Registers: `q_prev` (WIDTH), `hi` (HI_WIDTH), `load_d`, `ud_d`, FIFO storage, read/write pointers, entry count.
- FSM states: PRIME (after reset) and TRACK.
- PRIME: capture `q_prev <= qd` and `hi <= 0`; push no event; go to TRACK on the next edge.
- TRACK: compute `delta = qd - q_prev` mod 2^WIDTH, then apply the first matching rule:
  - `load_d == 1`: accept any `qd`; `hi` unchanged; push LOAD.
  - `delta == 0`: hold; no event.
  - `delta == 1` and `ud_d == 1`: step up. If `q_prev` is all-ones and `qd == 0`, then `hi <= hi+1` (wraps mod 2^HI_WIDTH) and push WRAP_UP.
  - `delta == all-ones` and `ud_d == 0`: step down. If `q_prev == 0` and `qd` is all-ones, then `hi <= hi-1` (wraps) and push WRAP_DN.
  - Anything else is an illegal jump. It is handled according to the Configuration section; `hi` is unchanged in both builds.
- Every TRACK cycle: `q_prev <= qd`, `load_d <= load`, `ud_d <= up_down`.
- FIFO behaviour:
  - Push when an event is generated; pop when `ev_valid && ev_ready`.
  - Push while full with no pop in the same cycle: the event is dropped and `ev_overflow <= 1`.
  - Push while full with a pop in the same cycle: both succeed.
  - Pop while empty has no effect.
- `ev_overflow` and `jump_err` stay set until `clear`.

## Timing
- All outputs are registered.
- Reset values (the cycle after `clear` is sampled high): `pos=0`, `ev_valid=0`, `ev_code=00`, `ev_pos=0`, `ev_overflow=0`, `jump_err=0`; FSM in PRIME; FIFO empty.
- `pos` reflects `qd` sampled at edge k immediately after edge k, so latency is 1 cycle.
- An event generated at edge k appears on `ev_valid` after edge k when the FIFO was empty (first-word fall-through).
- `load` at edge k: the counter changes `qd` after edge k, and the tracker classifies that change as LOAD at edge k+1.
- `clear` asserted mid-operation:
  - Flushes the FIFO, zeroes `hi`, and returns the FSM to PRIME.
  - Any handshake in flight in that cycle is discarded.
  - `ev_ready` is ignored while `clear` is high.
- `ev_code` and `ev_pos` hold steady while `ev_valid && !ev_ready`.

## Configuration
- `WRAP_TRACK_JUMP_CHECK_EN` defined:
  - An illegal jump pushes a JUMP event (code 00) carrying the resynced `pos`.
  - It also sets `jump_err`.
  - `q_prev` resyncs to `qd`.
- Not defined:
  - An illegal jump silently resyncs `q_prev` and pushes no event.
  - `jump_err` is tied to 0.
  - Code 00 is never produced.

## Test plan
- Reset and prime: `clear` for 2 cycles with `qd=0x10`, then release → `pos=0x0010` two cycles later; `ev_valid=0`.
- Up wrap: `qd` steps 0xFE, 0xFF, 0x00 with `up_down=1` → `pos=0x0100`; one WRAP_UP event with `ev_pos=0x0100`.
- Down wrap: from `pos=0x0100`, `qd` steps to 0xFF with `up_down=0` → `pos=0x00FF`; WRAP_DN event with `ev_pos=0x00FF`.
- Load resync: `load=1` with the counter loading 0x5A → next cycle LOAD event with `ev_pos={hi,0x5A}`; no `jump_err`.
- Illegal jump, macro defined: `qd` goes 0x20→0x30 with no `load` → JUMP event, `jump_err=1`, `hi` unchanged. Macro undefined: no event and `jump_err=0`.
- Overflow: hold `ev_ready=0` and generate 5 wraps → 4 events queued and `ev_overflow=1`. Then a push with `ev_ready=1` while full → no further drop; entry count stays 4.
